r_burst_drain_ctrl: RTL and testbench
=====================================

Name: r_burst_drain_ctrl

Overview:
- Read-domain controller that sequences pops from the async FIFO read-pointer/empty-flag logic and drains them downstream as bursts.
- It computes FIFO occupancy from the synchronized write pointer and the local read pointer, both Gray-coded.
- A fixed-length burst starts when occupancy reaches a threshold; a partial burst is flushed after an idle timeout.
- It sits between the FIFO read port (r_inc, r_empty, r_ptr, r_q2_w_ptr, memory read data) and a valid/ready consumer.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8, FIFO word width.
- TO_WIDTH, 8, width of the idle-timeout counter and cfg_timeout.

Ports:
- r_clk  in  1  read-domain clock (only clock).
- r_rst_n  in  1  asynchronous active-low reset.
- r_empty  in  1  FIFO empty flag.
- r_ptr  in  ADDR_WIDTH+1  FIFO read pointer, Gray.
- r_q2_w_ptr  in  ADDR_WIDTH+1  synchronized write pointer, Gray.
- r_rdata  in  DATA_WIDTH  memory data at the current read address; combinational, valid same cycle.
- r_inc  out  1  pop request to the FIFO read logic.
- enable  in  1  permits new bursts to start.
- cfg_burst_len  in  ADDR_WIDTH+1  burst threshold/length; 0 is treated as 1; values above 2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH.
- cfg_timeout  in  TO_WIDTH  idle cycles before a partial flush; 0 disables flush.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_WIDTH  output beat data.
- out_last  out  1  marks the final beat of a burst.
- out_ready  in  1  consumer accepts the beat.
- busy  out  1  high while state = BURST or out_valid is high.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - out_valid, out_last, r_inc and busy = 0.
  - out_data = 0; beats_left = 0; to_cnt = 0.
- Occupancy (combinational): occ = gray2bin(r_q2_w_ptr) - gray2bin(r_ptr), modulo 2^(ADDR_WIDTH+1). Range 0..2^ADDR_WIDTH, correct across pointer wrap. Occupancy may under-report by the synchronizer lag; it never over-reports.
- len_eff = clamp(max(cfg_burst_len, 1), 2^ADDR_WIDTH).
- IDLE state:
  - If enable and occ >= len_eff: beats_left <= len_eff, to_cnt <= 0, go to BURST.
  - Otherwise, if enable, cfg_timeout != 0, occ > 0 and to_cnt == cfg_timeout - 1: beats_left <= occ, to_cnt <= 0, go to BURST (flush).
  - Otherwise to_cnt increments while enable and occ > 0, and clears to 0 when occ == 0 or enable == 0.
  - The threshold check has priority over the timeout check when both are true in the same cycle.
- BURST state:
  - load = beats_left != 0 and !r_empty and (!out_valid or out_ready).
  - r_inc = load (combinational). r_inc is never asserted in IDLE or while r_empty = 1.
  - On load: out_data <= r_rdata, out_valid <= 1, out_last <= (beats_left == 1), beats_left decrements.
  - When load occurs with beats_left == 1: go to IDLE next cycle.
  - enable deasserting mid-burst does not abort the burst; the burst completes.
- Output handshake:
  - out_valid/out_data/out_last hold stable until out_ready is seen.
  - A handshake without a simultaneous load sets out_valid <= 0 and out_last <= 0.
  - A handshake with a simultaneous load keeps out_valid = 1 (back-to-back, one beat per cycle).
- Pop timing: pop-to-out_valid latency is 1 cycle. Full throughput is 1 beat/cycle when out_ready is held high.
- A new burst may start in IDLE while the last beat of the previous burst is still pending; its first load waits for the output slot to free.
- If r_empty = 1 in BURST (possible only through lag), the controller stalls without popping; no deadlock, it resumes when data appears.
- Reset asserted mid-burst returns all state to reset values immediately. Beats already popped but not yet delivered are dropped.

Test Plan:
- ADDR_WIDTH=4, cfg_burst_len=4, cfg_timeout=0, out_ready=1; write 4 words A0..A3:
  - Expect 4 consecutive beats A0..A3, out_last only on A3, and exactly 4 r_inc pulses.
  - Expect r_inc on the first BURST cycle and out_valid one cycle later.
- cfg_burst_len=8, cfg_timeout=10; write 3 words and stop:
  - Expect no output until to_cnt expires 10 cycles after occ first became nonzero.
  - Then expect a 3-beat burst with out_last on beat 3.
- cfg_burst_len=4; toggle out_ready as 1,0,0,1,1,0,1 during a burst:
  - Expect out_data stable while stalled, no r_inc while out_valid && !out_ready, and all 4 beats in order.
- Pointer wrap: push/pop 40 words total in bursts of 4 (pointers wrap past 31→0):
  - Expect occ correct at wrap, 10 bursts, no lost or duplicated data.
- cfg_burst_len=0 and cfg_burst_len=31:
  - Expect single-beat bursts for 0.
  - Expect 16-beat bursts only at full (occ=16) for 31.
- Assert r_rst_n mid-burst after 2 beats:
  - Expect out_valid=0, r_inc=0 and state IDLE in the same cycle.
  - After release, expect no output until occ >= len_eff.

Source files
------------

// File: rtl/r_burst_drain_ctrl.sv
// Read-domain burst drain controller for an async FIFO.
// Pops words as fixed bursts on threshold, or flushes a partial burst on idle timeout.
module r_burst_drain_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TO_WIDTH   = 8
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic                  r_empty,
    input  logic [ADDR_WIDTH:0]   r_ptr,
    input  logic [ADDR_WIDTH:0]   r_q2_w_ptr,
    input  logic [DATA_WIDTH-1:0] r_rdata,
    output logic                  r_inc,
    input  logic                  enable,
    input  logic [ADDR_WIDTH:0]   cfg_burst_len,
    input  logic [TO_WIDTH-1:0]   cfg_timeout,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_beats_left;
    logic [TO_WIDTH-1:0]   r_to_cnt;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic [PW-1:0]         w_w_bin;
    logic [PW-1:0]         w_r_bin;
    logic [PW-1:0]         w_occ;
    logic [PW-1:0]         w_len_eff;
    logic                  w_start_thr;
    logic                  w_start_to;
    logic                  w_load;
    logic                  w_hs;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_w_bin = gray2bin(r_q2_w_ptr);
    assign w_r_bin = gray2bin(r_ptr);
    // Modulo subtraction keeps occupancy correct across pointer wrap.
    assign w_occ   = w_w_bin - w_r_bin;

    always_comb begin
        w_len_eff = cfg_burst_len;
        if (cfg_burst_len == '0) begin
            w_len_eff = ONE;
        end else if (cfg_burst_len > DEPTH) begin
            w_len_eff = DEPTH;
        end
    end

    assign w_start_thr = enable && (w_occ >= w_len_eff);
    assign w_start_to  = enable && (cfg_timeout != '0) && (w_occ != '0)
                         && (r_to_cnt == cfg_timeout - TO_WIDTH'(1));

    assign w_hs   = r_out_valid && out_ready;
    assign w_load = (r_state == BURST) && (r_beats_left != '0) && !r_empty
                    && (!r_out_valid || out_ready);

    assign r_inc     = w_load;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state == BURST) || r_out_valid;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_to_cnt     <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
        end else begin
            if (w_load) begin
                r_out_data   <= r_rdata;
                r_out_valid  <= 1'b1;
                r_out_last   <= (r_beats_left == ONE);
                r_beats_left <= r_beats_left - ONE;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_start_thr) begin
                        r_beats_left <= w_len_eff;
                        r_to_cnt     <= '0;
                        r_state      <= BURST;
                    end else if (w_start_to) begin
                        r_beats_left <= w_occ;
                        r_to_cnt     <= '0;
                        r_state      <= BURST;
                    end else if (enable && (w_occ != '0)) begin
                        r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
                    end else begin
                        r_to_cnt <= '0;
                    end
                end
                BURST: begin
                    // Stalls without popping while empty; enable is ignored here.
                    if (w_load && (r_beats_left == ONE)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r_burst_drain_ctrl.sv
// Bench for r_burst_drain_ctrl: behavioural FIFO model plus scoreboard.
// Stimulus pushes expected beats; a monitor pops and compares on handshakes.
`timescale 1ns/1ps
module tb_r_burst_drain_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [4:0] cfg_burst_len = 5'd4;
    logic [7:0] cfg_timeout = 8'd0;
    logic       out_ready = 1'b1;
    logic       r_empty;
    logic [4:0] r_ptr;
    logic [4:0] r_q2_w_ptr;
    logic [7:0] r_rdata;
    logic       r_inc;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    always #5 clk = ~clk;

    r_burst_drain_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TO_WIDTH(8)) dut (
        .r_clk(clk), .r_rst_n(rst_n), .r_empty(r_empty), .r_ptr(r_ptr),
        .r_q2_w_ptr(r_q2_w_ptr), .r_rdata(r_rdata), .r_inc(r_inc),
        .enable(enable), .cfg_burst_len(cfg_burst_len),
        .cfg_timeout(cfg_timeout), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy)
    );

    // FIFO model: write side, two-stage pointer synchronizer, read pointer.
    logic [7:0] mem [16];
    logic [4:0] wbin, rbin, s1, s2, sb1, sb2, fill, occ_m;
    logic       w_en = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       full;

    function automatic logic [4:0] g2(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin <= 5'd0; rbin <= 5'd0;
            s1 <= 5'd0; s2 <= 5'd0; sb1 <= 5'd0; sb2 <= 5'd0;
        end else begin
            if (w_en && !full) begin
                mem[wbin[3:0]] <= w_data;
                wbin <= wbin + 5'd1;
            end
            s1 <= g2(wbin); s2 <= s1;
            sb1 <= wbin; sb2 <= sb1;
            if (r_inc) rbin <= rbin + 5'd1;
        end
    end

    assign fill       = wbin - rbin;
    assign full       = (fill == 5'd16);
    assign occ_m      = sb2 - rbin;
    assign r_ptr      = g2(rbin);
    assign r_q2_w_ptr = s2;
    assign r_empty    = (r_ptr == s2);
    assign r_rdata    = mem[rbin[3:0]];

    int checks = 0;
    int errors = 0;
    logic [8:0] sb [$];
    logic [8:0] e;
    int cyc = 0, rcv = 0, n_inc = 0, n_last = 0;
    int first_occ = -1, first_inc = -1;
    logic p_inc = 1'b0, p_stall = 1'b0, p_last = 1'b0;
    logic [7:0] p_data = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                p_inc = 1'b0; p_stall = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    checks++; rcv++;
                    if (out_last) n_last++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected got %h last %b", out_data, out_last);
                    end else begin
                        e = sb.pop_front();
                        if ({out_last, out_data} !== e) begin
                            errors++;
                            $display("FAIL beat got %b_%h want %b_%h",
                                     out_last, out_data, e[8], e[7:0]);
                        end
                    end
                end
                if (r_inc) begin
                    checks++; n_inc++;
                    if (r_empty || (out_valid && !out_ready)) begin
                        errors++;
                        $display("FAIL inc_illegal empty %b valid %b ready %b",
                                 r_empty, out_valid, out_ready);
                    end
                end
                if (p_inc) begin
                    checks++;
                    if (!out_valid) begin
                        errors++;
                        $display("FAIL pop_latency got valid 0 want 1");
                    end
                end
                if (p_stall) begin
                    checks++;
                    if (!out_valid || out_data !== p_data || out_last !== p_last) begin
                        errors++;
                        $display("FAIL hold got %b_%h want %b_%h", out_last,
                                 out_data, p_last, p_data);
                    end
                end
                if (out_valid) begin
                    checks++;
                    if (!busy) begin
                        errors++;
                        $display("FAIL busy got 0 want 1");
                    end
                end
                if (occ_m != 5'd0 && first_occ < 0) first_occ = cyc;
                if (r_inc && first_inc < 0) first_inc = cyc;
                p_inc = r_inc;
                p_stall = out_valid && !out_ready;
                p_data = out_data;
                p_last = out_last;
            end
        end
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        int n = 0;
        while (full && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (full) begin
            errors++;
            $display("FAIL push_full got full 1 want 0");
        end
        sb.push_back({last, d});
        w_en = 1'b1; w_data = d;
        @(posedge clk); #1;
        w_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid || busy) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid || busy) begin
            errors++;
            $display("FAIL drain got pending %0d want 0", sb.size());
        end
    endtask

    task automatic quiet(input string nm, input int n);
        logic bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (out_valid || r_inc) bad = 1'b1;
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int base, nb;

    initial begin
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_inc", 32'(r_inc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1; enable = 1'b1;
        @(posedge clk); #1;

        base = n_inc;
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), i == 3);
        drain();
        chk("t1_incs", 32'(n_inc - base), 32'd4);

        cfg_burst_len = 5'd8; cfg_timeout = 8'd10;
        first_occ = -1; first_inc = -1;
        for (int i = 0; i < 3; i++) push(8'hB0 + 8'(i), i == 2);
        drain();
        chk("flush_delay", 32'(first_inc - first_occ), 32'd10);
        cfg_timeout = 8'd0; cfg_burst_len = 5'd4;

        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), i == 3);
        nb = 0;
        while (!out_valid && nb < 100) begin
            @(posedge clk); #1; nb++;
        end
        chk("t3_start", 32'(out_valid), 32'd1);
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        base = n_last;
        for (int i = 0; i < 40; i++) push(8'h40 + 8'(i), (i % 4) == 3);
        drain();
        chk("wrap_bursts", 32'(n_last - base), 32'd10);

        cfg_burst_len = 5'd0;
        base = n_last;
        for (int i = 0; i < 3; i++) push(8'hD0 + 8'(i), 1'b1);
        drain();
        chk("len0_bursts", 32'(n_last - base), 32'd3);

        cfg_burst_len = 5'd31;
        for (int i = 0; i < 15; i++) push(8'hE0 + 8'(i), 1'b0);
        quiet("len31_quiet", 20);
        chk("len31_occ", 32'(occ_m), 32'd15);
        base = n_inc;
        push(8'hEF, 1'b1);
        drain();
        chk("len31_incs", 32'(n_inc - base), 32'd16);

        cfg_burst_len = 5'd4;
        base = rcv;
        for (int i = 0; i < 4; i++) push(8'hF0 + 8'(i), i == 3);
        nb = 0;
        while (rcv < base + 2 && nb < 100) begin
            @(posedge clk); nb++;
        end
        chk("rst_mid_reach", 32'(rcv - base), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_inc", 32'(r_inc), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) push(8'h10 + 8'(i), 1'b0);
        quiet("post_rst_quiet", 15);
        push(8'h13, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
